// File: rtl/prog_loader.sv
// Boot loader: streams words into RAM from an aligned base, reads them back to verify a 16-bit checksum, then pulses cpu_start.
// One RAM write the cycle after each accepted beat; readback takes word_count+1 cycles; s_ready drops after the last beat or on overflow.
module prog_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WORDS  = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_go,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [11:0]           word_count,
    output logic                  cpu_start,
    output logic [15:0]           cpu_pc
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK     = ~(ADDR_WIDTH'(1));
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD_ADDR = ALIGN_MASK;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP      = ADDR_WIDTH'(2);
    localparam logic [11:0]           MAX_CNT        = 12'(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VRD,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [DATA_WIDTH-1:0] vsum_q, vsum_d;
    logic [11:0]           vcyc_q, vcyc_d;
    logic                  fin_q, fin_d;
    logic                  ovf_q, ovf_d;

    logic                  s_ready_q, s_ready_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  ram_cs_q, ram_cs_d;
    logic                  ram_we_q, ram_we_d;
    logic                  ram_oe_q, ram_oe_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [11:0]           word_count_q, word_count_d;
    logic                  cpu_start_q, cpu_start_d;
    logic [15:0]           cpu_pc_q, cpu_pc_d;

    logic                  accept;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        wr_addr_d    = wr_addr_q;
        sum_d        = sum_q;
        vsum_d       = vsum_q;
        vcyc_d       = vcyc_q;
        fin_d        = fin_q;
        ovf_d        = ovf_q;
        s_ready_d    = s_ready_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_cs_d     = ram_cs_q;
        ram_we_d     = 1'b0;
        ram_oe_d     = ram_oe_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        word_count_d = word_count_q;
        cpu_start_d  = 1'b0;
        cpu_pc_d     = cpu_pc_q;
        accept       = (state_q == ST_LOAD) && s_valid && s_ready_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (load_go) begin
                    state_d      = ST_LOAD;
                    base_d       = base_addr & ALIGN_MASK;
                    wr_addr_d    = base_addr & ALIGN_MASK;
                    sum_d        = '0;
                    word_count_d = '0;
                    fin_d        = 1'b0;
                    ovf_d        = 1'b0;
                    s_ready_d    = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    ram_cs_d     = 1'b0;
                    ram_oe_d     = 1'b0;
                end
            end

            ST_LOAD: begin
                ram_cs_d = 1'b0;
                if (fin_q) begin
                    // final word's write is on the bus this cycle; start readback next
                    state_d    = ST_VRD;
                    ram_addr_d = base_q;
                    ram_cs_d   = 1'b1;
                    ram_oe_d   = 1'b1;
                    vsum_d     = '0;
                    vcyc_d     = '0;
                end else if (ovf_q) begin
                    state_d = ST_ERR;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else if (accept) begin
                    ram_addr_d   = wr_addr_q;
                    ram_wdata_d  = s_data;
                    ram_cs_d     = 1'b1;
                    ram_we_d     = 1'b1;
                    wr_addr_d    = wr_addr_q + ADDR_STEP;
                    word_count_d = word_count_q + 12'd1;
                    sum_d        = sum_q + s_data;
                    if (s_last) begin
                        fin_d     = 1'b1;
                        s_ready_d = 1'b0;
                    end else if ((wr_addr_q == LAST_WORD_ADDR) ||
                                 (word_count_q + 12'd1 == MAX_CNT)) begin
                        // the next address would wrap or exceed the session limit
                        ovf_d     = 1'b1;
                        s_ready_d = 1'b0;
                    end
                end
            end

            ST_VRD: begin
                // data for the address presented last cycle arrives now
                if (vcyc_q != 12'd0) begin
                    vsum_d = vsum_q + ram_rdata;
                end
                if (vcyc_q + 12'd1 < word_count_q) begin
                    ram_addr_d = ram_addr_q + ADDR_STEP;
                end else begin
                    ram_cs_d = 1'b0;
                    ram_oe_d = 1'b0;
                end
                if (vcyc_q == word_count_q) begin
                    busy_d = 1'b0;
                    if (vsum_d == sum_q) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        cpu_start_d = 1'b1;
                        cpu_pc_d    = 16'(base_q);
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
                vcyc_d = vcyc_q + 12'd1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            wr_addr_q    <= '0;
            sum_q        <= '0;
            vsum_q       <= '0;
            vcyc_q       <= '0;
            fin_q        <= 1'b0;
            ovf_q        <= 1'b0;
            s_ready_q    <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
            cpu_start_q  <= 1'b0;
            cpu_pc_q     <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            wr_addr_q    <= wr_addr_d;
            sum_q        <= sum_d;
            vsum_q       <= vsum_d;
            vcyc_q       <= vcyc_d;
            fin_q        <= fin_d;
            ovf_q        <= ovf_d;
            s_ready_q    <= s_ready_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_cs_q     <= ram_cs_d;
            ram_we_q     <= ram_we_d;
            ram_oe_q     <= ram_oe_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            word_count_q <= word_count_d;
            cpu_start_q  <= cpu_start_d;
            cpu_pc_q     <= cpu_pc_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_cs     = ram_cs_q;
    assign ram_we     = ram_we_q;
    assign ram_oe     = ram_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = word_count_q;
    assign cpu_start  = cpu_start_q;
    assign cpu_pc     = cpu_pc_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream boot stage for the accumulator CPU.
- Accepts a stream of 16-bit program/data words over a valid/ready handshake and writes them into large_ram at consecutive even (word-aligned) addresses from a base address.
- Reads the image back to verify a 16-bit checksum.
- On success, pulses cpu_start with the entry PC. This replaces hand-written testbench preload sequences.

Parameters:
ADDR_WIDTH, 12, RAM address width (byte address, words at even addresses)
DATA_WIDTH, 16, word width
MAX_WORDS, 2048, maximum words per load session

Ports:
clk  input  1  clock, all state changes on posedge
rst  input  1  reset; asynchronous, active-high
load_go  input  1  single-cycle request to start a session
base_addr  input  ADDR_WIDTH  first write address; bit 0 forced to 0
s_valid  input  1  stream word valid
s_data  input  DATA_WIDTH  stream word
s_last  input  1  marks final word of image
s_ready  output  1  loader can accept a word
ram_addr  output  ADDR_WIDTH  RAM address (drives MAR)
ram_wdata  output  DATA_WIDTH  RAM write data
ram_rdata  input  DATA_WIDTH  RAM read data
ram_cs  output  1  chip select
ram_we  output  1  write enable
ram_oe  output  1  output enable
busy  output  1  session in progress
done  output  1  image loaded and verified
err  output  1  overflow or checksum mismatch
word_count  output  12  words written in the current or last session
cpu_start  output  1  one-cycle pulse on verified completion
cpu_pc  output  16  entry PC (zero-extended aligned base), valid when done=1

Behaviour:
- All outputs are registered.
- On rst=1, asynchronously and immediately:
  - state=IDLE.
  - s_ready, ram_cs, ram_we, ram_oe, busy, done, err, cpu_start = 0.
  - ram_addr, ram_wdata, word_count, cpu_pc = 0.
- Reset mid-session abandons the load; no further RAM writes occur.
- IDLE:
  - s_ready=0.
  - load_go=1 -> LOAD: wr_addr=base_addr&~1, base latched, sum=0, word_count=0, busy=1, done=0, err=0.
- LOAD:
  - s_ready=1 unless an overflow is pending.
  - A beat is accepted on a posedge with s_valid&s_ready.
  - The following cycle drives ram_addr=wr_addr, ram_wdata=s_data, ram_cs=1, ram_we=1, ram_oe=0 (one write per accepted beat).
  - Per accepted beat: wr_addr += 2, word_count += 1, sum = (sum + s_data) mod 2^16.
  - Cycles without an accept drive ram_we=0.
  - Back-to-back accepts give one write per cycle.
  - Accepted beat with s_last=1 -> VRD after its write cycle; s_ready=0 from the cycle after that accept.
  - Overflow: an accepted non-last beat written at address 2^ADDR_WIDTH-2, or word_count reaching MAX_WORDS without s_last, -> ERR.
    - s_ready drops the next cycle.
    - The word that triggered it is still written.
    - No wrap-around write to address 0 ever occurs.
- VRD (readback):
  - rd_addr starts at the latched base; ram_cs=1, ram_oe=1, ram_we=0.
  - One address is presented per cycle for word_count words.
  - ram_rdata for the address presented at cycle k is sampled at the posedge ending cycle k+1 (1-cycle RAM latency), added into vsum mod 2^16.
  - After the last sample: vsum==sum -> DONE, else ERR.
  - Minimum VRD duration is word_count+1 cycles.
- DONE:
  - done=1, busy=0, ram_cs=ram_oe=ram_we=0, cpu_pc={4'b0, base}.
  - cpu_start=1 for exactly the first cycle in DONE.
- ERR:
  - err=1, busy=0, RAM signals idle, no cpu_start.
- DONE and ERR hold until load_go, which restarts as from IDLE (done/err cleared the next cycle).
- load_go while busy=1 is ignored.
- s_valid outside LOAD is ignored; no state change.
- word_count holds its final value in DONE/ERR.

Test Plan:
- Fibonacci image (23 words 0x111C,0x711A,...,0x0122, s_last on 23rd), base=0x100, s_valid continuous:
  - RAM 0x100..0x12C holds the image.
  - word_count=23, 23 write cycles.
  - done=1, cpu_pc=0x0100, single cpu_start pulse, err=0.
- Same image with s_valid deasserted randomly ~50%:
  - Identical RAM contents and result.
  - ram_we high only on cycles following accepts.
- Checksum mismatch: RAM model corrupts the word at 0x10A during readback -> err=1, done=0, no cpu_start.
- Overflow: base=0xFFC, 3 words with s_last on the 3rd:
  - Writes only at 0xFFC and 0xFFE; nothing written to 0x000.
  - err=1, s_ready=0 afterwards.
- Odd base 0x101 with 2 words -> writes at 0x100, 0x102; cpu_pc=0x0100.
- rst pulsed after 5 accepted words:
  - All outputs 0 immediately, no further RAM writes.
  - A subsequent load_go performs a fresh load with word_count restarting at 0.
- load_go asserted during LOAD -> ignored; session completes normally.
